pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Parametrised next-generation program counter for the team's small sequencer/CPU datapaths.
- Adds over the existing fixed 8-bit PC:
  - configurable address width
  - signed relative branch
  - call/return through an internal return-address stack (RAS) of configurable depth
  - wrap detection
  - sticky stack error flags
- Sits between instruction decode (commands) and instruction memory address port (pc_out).

Parameters:
- WIDTH, 16, PC/address width in bits (≥4).
- STEP_W, 3, width of unsigned step_size.
- STACK_DEPTH, 4, number of RAS entries (≥1).
- RESET_ADDR, 0, value loaded into pc_out on reset (WIDTH bits).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  when 0 all state frozen, commands ignored.
- hold  input  1  PC and stack hold this cycle.
- ret  input  1  pop RAS into PC.
- call  input  1  push return address, jump to call_target.
- call_target  input  WIDTH  absolute call destination.
- load  input  1  absolute jump to load_value.
- load_value  input  WIDTH  absolute load destination.
- branch  input  1  relative jump.
- branch_offset  input  WIDTH  two's-complement offset added to pc_out.
- step_size  input  STEP_W  unsigned default increment; also return-address offset for call.
- pc_out  output  WIDTH  registered current PC.
- stack_count  output  $clog2(STACK_DEPTH+1)  valid RAS entries.
- stack_empty  output  1  stack_count==0 (combinational from count).
- stack_full  output  1  stack_count==STACK_DEPTH.
- pc_wrap  output  1  registered one-cycle pulse: last update was a step that carried out of WIDTH bits.
- overflow_err  output  1  sticky: call attempted while full.
- underflow_err  output  1  sticky: ret attempted while empty.

Behaviour:
- All state updates on rising clk; outputs registered; command sampled at edge N is visible on pc_out after edge N (1-cycle latency).
- Reset (synchronous, dominates everything):
  - pc_out=RESET_ADDR
  - stack_count=0
  - pc_wrap=0, overflow_err=0, underflow_err=0
  - RAS contents don't-care.
- Priority, evaluated only when enable=1; exactly one action per cycle, lower-priority commands ignored:
  - 1. hold:
    - pc_out and stack unchanged.
  - 2. ret:
    - if stack_count>0: pc_out<=top entry, count-1.
    - else: pc_out unchanged, underflow_err<=1.
  - 3. call:
    - if !stack_full: push (pc_out+step_size) mod 2^WIDTH, count+1, pc_out<=call_target.
    - else: no push, pc_out unchanged, overflow_err<=1.
  - 4. load:
    - pc_out<=load_value.
  - 5. branch:
    - pc_out<=(pc_out+branch_offset) mod 2^WIDTH, signed, no saturation.
  - 6. default:
    - pc_out<=(pc_out+zero-extended step_size) mod 2^WIDTH.
    - step_size=0 is legal and holds the PC.
- enable=0: pc_out, stack and sticky flags unchanged; pc_wrap<=0.
- pc_wrap: set to 1 only on a default-step update whose WIDTH+1-bit sum has carry out; 0 on every other cycle, including branch/call/load/ret wraps.
- RAS is LIFO: top = most recently pushed.
- Sticky errors clear only via reset; they do not block further operation.
- Simultaneous call+ret: ret wins; call is dropped without a push.

Test Plan:
- Reset then 3 default steps, step_size=2, RESET_ADDR=0x0010 -> pc_out 0x0010, 0x0012, 0x0014, 0x0016.
- pc_out=0xFFFE, step_size=3 -> pc_out=0x0001 and pc_wrap=1 for exactly one cycle.
- pc_out=0x0100, call call_target=0x0800, step_size=1 -> pc_out=0x0800, stack_count=1. Then ret -> pc_out=0x0101, stack_empty=1.
- 4 nested calls fill stack (stack_full=1). 5th call -> pc_out unchanged, overflow_err=1. Then 4 rets return in reverse push order. 5th ret -> pc_out unchanged, underflow_err=1.
- pc_out=0x0040, branch_offset=0xFFF0 (-16) -> pc_out=0x0030. Same cycle with load=1, load_value=0x1234 -> 0x1234 (load beats branch).
- Mid-sequence with stack_count=2 and both error flags set, assert reset one cycle -> pc_out=RESET_ADDR, stack_count=0, errors 0. Also check that enable=0 with call=1 changes nothing.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: parametrised program counter with a signed relative branch,
// call/return through a small return-address stack, a one-cycle wrap pulse
// on default steps, and sticky stack overflow/underflow flags.
module pc_sequencer #(
    parameter int               WIDTH       = 16,
    parameter int               STEP_W      = 3,
    parameter int               STACK_DEPTH = 4,
    parameter logic [WIDTH-1:0] RESET_ADDR  = '0
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               enable,
    input  logic                               hold,
    input  logic                               ret,
    input  logic                               call,
    input  logic [WIDTH-1:0]                   call_target,
    input  logic                               load,
    input  logic [WIDTH-1:0]                   load_value,
    input  logic                               branch,
    input  logic [WIDTH-1:0]                   branch_offset,
    input  logic [STEP_W-1:0]                  step_size,
    output logic [WIDTH-1:0]                   pc_out,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   stack_count,
    output logic                               stack_empty,
    output logic                               stack_full,
    output logic                               pc_wrap,
    output logic                               overflow_err,
    output logic                               underflow_err
);

    localparam int CNT_W = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    // One action per enabled cycle, chosen by fixed priority.
    typedef enum logic [2:0] {
        ActIdle,
        ActHold,
        ActRet,
        ActCall,
        ActLoad,
        ActBranch,
        ActStep
    } action_e;

    action_e           action;

    logic [WIDTH-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              wrap_q, wrap_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;

    logic [WIDTH-1:0]  stack_q [STACK_DEPTH];
    logic              pushEn;
    logic [WIDTH-1:0]  pushData;
    logic [IDX_W-1:0]  pushIdx;
    logic [IDX_W-1:0]  topIdx;
    logic [CNT_W-1:0]  countMinusOne;

    logic [WIDTH:0]    stepSum;
    logic [WIDTH-1:0]  branchSum;
    logic [WIDTH-1:0]  retAddr;
    logic              isEmpty;
    logic              isFull;

    assign isEmpty       = (count_q == '0);
    assign isFull        = (count_q == CNT_W'(STACK_DEPTH));
    assign countMinusOne = count_q - CNT_W'(1);
    assign pushIdx       = count_q[IDX_W-1:0];
    assign topIdx        = countMinusOne[IDX_W-1:0];

    // The extra top bit of the step sum is the carry that drives pc_wrap.
    assign stepSum   = {1'b0, pc_q} + (WIDTH+1)'(step_size);
    assign branchSum = pc_q + branch_offset;
    assign retAddr   = pc_q + WIDTH'(step_size);

    // Decode the command inputs into a single prioritised action.
    always_comb begin
        action = ActIdle;
        if (enable) begin
            if (hold)        action = ActHold;
            else if (ret)    action = ActRet;
            else if (call)   action = ActCall;
            else if (load)   action = ActLoad;
            else if (branch) action = ActBranch;
            else             action = ActStep;
        end
    end

    // Next-state computation for PC, stack count, push and flags.
    always_comb begin
        pc_d     = pc_q;
        count_d  = count_q;
        wrap_d   = 1'b0;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        pushEn   = 1'b0;
        pushData = retAddr;
        case (action)
            ActRet: begin
                if (!isEmpty) begin
                    pc_d    = stack_q[topIdx];
                    count_d = countMinusOne;
                end else begin
                    unf_d = 1'b1;
                end
            end
            ActCall: begin
                if (!isFull) begin
                    pushEn  = 1'b1;
                    count_d = count_q + CNT_W'(1);
                    pc_d    = call_target;
                end else begin
                    ovf_d = 1'b1;
                end
            end
            ActLoad:   pc_d = load_value;
            ActBranch: pc_d = branchSum;
            ActStep: begin
                pc_d   = stepSum[WIDTH-1:0];
                wrap_d = stepSum[WIDTH];
            end
            default: ;
        endcase
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= RESET_ADDR;
            count_q <= '0;
            wrap_q  <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            count_q <= count_d;
            wrap_q  <= wrap_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Return-address stack storage; contents need no reset because count gates them.
    always_ff @(posedge clk) begin
        if (!reset && pushEn) begin
            stack_q[pushIdx] <= pushData;
        end
    end

    assign pc_out        = pc_q;
    assign stack_count   = count_q;
    assign stack_empty   = isEmpty;
    assign stack_full    = isFull;
    assign pc_wrap       = wrap_q;
    assign overflow_err  = ovf_q;
    assign underflow_err = unf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed vectors with hand-computed expectations for pc_sequencer.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        hold;
    logic        ret;
    logic        call;
    logic [15:0] call_target;
    logic        load;
    logic [15:0] load_value;
    logic        branch;
    logic [15:0] branch_offset;
    logic [2:0]  step_size;
    logic [15:0] pc_out;
    logic [2:0]  stack_count;
    logic        stack_empty;
    logic        stack_full;
    logic        pc_wrap;
    logic        overflow_err;
    logic        underflow_err;

    int checkCount = 0;
    int errorCount = 0;

    pc_sequencer #(
        .WIDTH(16),
        .STEP_W(3),
        .STACK_DEPTH(4),
        .RESET_ADDR(16'h0010)
    ) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .hold(hold),
        .ret(ret),
        .call(call),
        .call_target(call_target),
        .load(load),
        .load_value(load_value),
        .branch(branch),
        .branch_offset(branch_offset),
        .step_size(step_size),
        .pc_out(pc_out),
        .stack_count(stack_count),
        .stack_empty(stack_empty),
        .stack_full(stack_full),
        .pc_wrap(pc_wrap),
        .overflow_err(overflow_err),
        .underflow_err(underflow_err)
    );

    always #5 clk = ~clk;

    // Compare one observed value against its expectation and tally the result.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of commands, then sample 1 time unit after the edge.
    task automatic applyStimulus(input logic en, input logic hd, input logic rt, input logic cl,
                                 input logic ld, input logic br, input logic [15:0] tgt,
                                 input logic [15:0] lv, input logic [15:0] off, input logic [2:0] step);
        enable        = en;
        hold          = hd;
        ret           = rt;
        call          = cl;
        load          = ld;
        branch        = br;
        call_target   = tgt;
        load_value    = lv;
        branch_offset = off;
        step_size     = step;
        @(posedge clk);
        #1;
    endtask

    logic [15:0] callTargets [5];
    logic [15:0] retExpect   [4];

    initial begin
        reset = 1'b1;
        applyStimulus(1, 0, 0, 0, 0, 0, 16'h0, 16'h0, 16'h0, 3'd2);
        reset = 1'b0;
        checkOutput("reset_pc",    32'(pc_out),        32'h0010);
        checkOutput("reset_count", 32'(stack_count),   32'd0);
        checkOutput("reset_empty", 32'(stack_empty),   32'd1);
        checkOutput("reset_full",  32'(stack_full),    32'd0);
        checkOutput("reset_wrap",  32'(pc_wrap),       32'd0);
        checkOutput("reset_ovf",   32'(overflow_err),  32'd0);
        checkOutput("reset_unf",   32'(underflow_err), 32'd0);

        // Three default steps of 2.
        for (int i = 1; i <= 3; i++) begin
            applyStimulus(1, 0, 0, 0, 0, 0, 16'h0, 16'h0, 16'h0, 3'd2);
            checkOutput("step2_pc", 32'(pc_out), 32'h0010 + 32'(2 * i));
        end

        // Default step wrap pulse.
        applyStimulus(1, 0, 0, 0, 1, 0, 16'h0, 16'hFFFE, 16'h0, 3'd3);
        checkOutput("load_fffe", 32'(pc_out), 32'hFFFE);
        checkOutput("load_nowrap", 32'(pc_wrap), 32'd0);
        applyStimulus(1, 0, 0, 0, 0, 0, 16'h0, 16'h0, 16'h0, 3'd3);
        checkOutput("wrap_pc",   32'(pc_out),  32'h0001);
        checkOutput("wrap_flag", 32'(pc_wrap), 32'd1);
        applyStimulus(1, 0, 0, 0, 0, 0, 16'h0, 16'h0, 16'h0, 3'd3);
        checkOutput("wrap_next_pc",   32'(pc_out),  32'h0004);
        checkOutput("wrap_next_flag", 32'(pc_wrap), 32'd0);

        // Single call and return.
        applyStimulus(1, 0, 0, 0, 1, 0, 16'h0, 16'h0100, 16'h0, 3'd1);
        applyStimulus(1, 0, 0, 1, 0, 0, 16'h0800, 16'h0, 16'h0, 3'd1);
        checkOutput("call_pc",    32'(pc_out),      32'h0800);
        checkOutput("call_count", 32'(stack_count), 32'd1);
        checkOutput("call_empty", 32'(stack_empty), 32'd0);
        applyStimulus(1, 0, 1, 0, 0, 0, 16'h0, 16'h0, 16'h0, 3'd1);
        checkOutput("ret_pc",    32'(pc_out),      32'h0101);
        checkOutput("ret_empty", 32'(stack_empty), 32'd1);

        // Nested calls to fill the stack, then overflow.
        callTargets = '{16'h1000, 16'h2000, 16'h3000, 16'h4000, 16'h5000};
        retExpect   = '{16'h3001, 16'h2001, 16'h1001, 16'h0102};
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 0, 0, 1, 0, 0, callTargets[i], 16'h0, 16'h0, 3'd1);
            checkOutput("nest_call_pc", 32'(pc_out), 32'(callTargets[i]));
            checkOutput("nest_call_count", 32'(stack_count), 32'(i + 1));
        end
        checkOutput("full_flag", 32'(stack_full), 32'd1);
        applyStimulus(1, 0, 0, 1, 0, 0, callTargets[4], 16'h0, 16'h0, 3'd1);
        checkOutput("ovf_pc",    32'(pc_out),       32'h4000);
        checkOutput("ovf_flag",  32'(overflow_err), 32'd1);
        checkOutput("ovf_count", 32'(stack_count),  32'd4);

        // Unwind in LIFO order, then underflow.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 0, 1, 0, 0, 0, 16'h0, 16'h0, 16'h0, 3'd1);
            checkOutput("nest_ret_pc", 32'(pc_out), 32'(retExpect[i]));
        end
        checkOutput("unwind_empty", 32'(stack_empty), 32'd1);
        applyStimulus(1, 0, 1, 0, 0, 0, 16'h0, 16'h0, 16'h0, 3'd1);
        checkOutput("unf_pc",     32'(pc_out),        32'h0102);
        checkOutput("unf_flag",   32'(underflow_err), 32'd1);
        checkOutput("ovf_sticky", 32'(overflow_err),  32'd1);

        // Signed branch, load priority, branch carry not flagged as wrap.
        applyStimulus(1, 0, 0, 0, 1, 0, 16'h0, 16'h0040, 16'h0, 3'd1);
        applyStimulus(1, 0, 0, 0, 0, 1, 16'h0, 16'h0, 16'hFFF0, 3'd1);
        checkOutput("branch_back", 32'(pc_out), 32'h0030);
        applyStimulus(1, 0, 0, 0, 1, 1, 16'h0, 16'h1234, 16'hFFF0, 3'd1);
        checkOutput("load_over_branch", 32'(pc_out), 32'h1234);
        applyStimulus(1, 0, 0, 0, 0, 1, 16'h0, 16'h0, 16'hF000, 3'd1);
        checkOutput("branch_carry_pc",   32'(pc_out),  32'h0234);
        checkOutput("branch_carry_wrap", 32'(pc_wrap), 32'd0);

        // Hold beats call.
        applyStimulus(1, 1, 0, 1, 0, 0, 16'h0999, 16'h0, 16'h0, 3'd1);
        checkOutput("hold_pc",    32'(pc_out),      32'h0234);
        checkOutput("hold_count", 32'(stack_count), 32'd0);

        // Simultaneous call and ret: ret wins, no push.
        applyStimulus(1, 0, 0, 1, 0, 0, 16'h0500, 16'h0, 16'h0, 3'd1);
        checkOutput("pre_both_count", 32'(stack_count), 32'd1);
        applyStimulus(1, 0, 1, 1, 0, 0, 16'h0600, 16'h0, 16'h0, 3'd1);
        checkOutput("both_pc",    32'(pc_out),      32'h0235);
        checkOutput("both_count", 32'(stack_count), 32'd0);

        // Build stack_count=2, then enable=0 with call freezes everything.
        applyStimulus(1, 0, 0, 1, 0, 0, 16'h0700, 16'h0, 16'h0, 3'd1);
        applyStimulus(1, 0, 0, 1, 0, 0, 16'h0800, 16'h0, 16'h0, 3'd1);
        checkOutput("two_count", 32'(stack_count), 32'd2);
        applyStimulus(0, 0, 0, 1, 0, 0, 16'h0900, 16'h0, 16'h0, 3'd1);
        checkOutput("disabled_pc",    32'(pc_out),        32'h0800);
        checkOutput("disabled_count", 32'(stack_count),   32'd2);
        checkOutput("disabled_ovf",   32'(overflow_err),  32'd1);
        checkOutput("disabled_unf",   32'(underflow_err), 32'd1);

        // Mid-sequence reset clears everything.
        reset = 1'b1;
        applyStimulus(1, 0, 0, 1, 0, 0, 16'h0A00, 16'h0, 16'h0, 3'd1);
        reset = 1'b0;
        checkOutput("rst2_pc",    32'(pc_out),        32'h0010);
        checkOutput("rst2_count", 32'(stack_count),   32'd0);
        checkOutput("rst2_ovf",   32'(overflow_err),  32'd0);
        checkOutput("rst2_unf",   32'(underflow_err), 32'd0);

        // Zero step holds PC.
        applyStimulus(1, 0, 0, 0, 0, 0, 16'h0, 16'h0, 16'h0, 3'd0);
        checkOutput("step0_pc",   32'(pc_out),  32'h0010);
        checkOutput("step0_wrap", 32'(pc_wrap), 32'd0);

        // After the stack was reset, the first push reuses slot 0.
        applyStimulus(1, 0, 0, 1, 0, 0, 16'h0C00, 16'h0, 16'h0, 3'd4);
        applyStimulus(1, 0, 1, 0, 0, 0, 16'h0, 16'h0, 16'h0, 3'd4);
        checkOutput("post_rst_ret", 32'(pc_out), 32'h0014);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
